// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// Shared types and default sizing for the I2C role arbiter.
package i2c_pkg;

    localparam int BUS_FREE_CYCLES_DEF = 64;
    localparam int STUCK_CYCLES_DEF    = 65535;
    localparam int CNT_W_DEF           = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FREE = 3'd1,
        MASTER    = 3'd2,
        SLAVE_EXT = 3'd3,
        ARB_LOST  = 3'd4
    } arb_state_t;

    // States in which an active transfer should keep SCL toggling
    function automatic logic scl_watched(input arb_state_t s);
        return (s == MASTER) || (s == SLAVE_EXT) || (s == ARB_LOST);
    endfunction

endpackage

// File: rtl/i2c_idle_counter.sv
`timescale 1ns/1ps
// Saturating up-counter; done flags the counting cycle that sits on the terminal value.
module i2c_idle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             count_en,
    input  logic             clear,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = count_en && (cnt_q == terminal);

endmodule

// File: rtl/i2c_role_arbiter.sv
`timescale 1ns/1ps
// Chooses whether the local master or local slave owns the shared I2C datapath,
// tracking bus free time, arbitration loss and SCL-stuck-low timeout.
module i2c_role_arbiter
    import i2c_pkg::*;
#(
    parameter int BUS_FREE_CYCLES = BUS_FREE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start_det,
    input  logic stop_det,
    input  logic SCL_sync,
    input  logic SDA_sync,
    input  logic scl_rise,
    input  logic master_req,
    input  logic master_sda_rel,
    input  logic master_done,
    input  logic arb_lost_clr,
    output logic master_grant,
    output logic slave_grant,
    output logic bus_free,
    output logic arb_lost,
    output logic timeout
);

    localparam logic [CNT_W-1:0] FREE_TERM  = CNT_W'(BUS_FREE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUCK_TERM = CNT_W'(STUCK_CYCLES - 1);

    arb_state_t state_q, state_d;
    logic       free_en_s, free_done_s;
    logic       stuck_en_s, stuck_done_s;
    logic       arb_cond_s, arb_set_s;
    logic       master_grant_q, slave_grant_q, bus_free_q, arb_lost_q, timeout_q;
    logic       arb_lost_d;

    assign free_en_s  = (state_q == WAIT_FREE) && SCL_sync && SDA_sync;
    assign stuck_en_s = scl_watched(state_q) && !SCL_sync;
    assign arb_cond_s = scl_rise && master_sda_rel && !SDA_sync;
    assign arb_set_s  = (state_q == ARB_LOST);

    i2c_idle_counter #(.CNT_W(CNT_W)) u_free_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .count_en (free_en_s),
        .clear    (!free_en_s),
        .terminal (FREE_TERM),
        .done     (free_done_s)
    );

    // Leaving the watched states also clears this counter because count_en drops
    i2c_idle_counter #(.CNT_W(CNT_W)) u_stuck_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .count_en (stuck_en_s),
        .clear    (!stuck_en_s || stuck_done_s),
        .terminal (STUCK_TERM),
        .done     (stuck_done_s)
    );

    // Next-state logic, priority timeout > stop > arbitration loss > start > request
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FREE: begin
                if (start_det)        state_d = SLAVE_EXT;
                else if (free_done_s) state_d = IDLE;
                else                  state_d = WAIT_FREE;
            end
            IDLE: begin
                if (start_det)       state_d = SLAVE_EXT;
                else if (master_req) state_d = MASTER;
                else                 state_d = IDLE;
            end
            MASTER: begin
                if (stuck_done_s)                  state_d = WAIT_FREE;
                else if (stop_det || master_done)  state_d = WAIT_FREE;
                else if (arb_cond_s)               state_d = ARB_LOST;
                else                               state_d = MASTER;
            end
            ARB_LOST: begin
                if (stuck_done_s || stop_det) state_d = WAIT_FREE;
                else                          state_d = SLAVE_EXT;
            end
            SLAVE_EXT: begin
                if (stuck_done_s || stop_det) state_d = WAIT_FREE;
                else                          state_d = SLAVE_EXT;
            end
            default: state_d = WAIT_FREE;
        endcase
    end

    // Sticky arbitration-loss flag, set-dominant over the clear pulse
    always_comb begin
        if (arb_set_s) begin
            arb_lost_d = 1'b1;
        end else if (arb_lost_clr) begin
            arb_lost_d = 1'b0;
        end else begin
            arb_lost_d = arb_lost_q;
        end
    end

    // State and output registers; grants are decoded from the next state so they track state_q
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= WAIT_FREE;
            master_grant_q <= 1'b0;
            slave_grant_q  <= 1'b1;
            bus_free_q     <= 1'b0;
            arb_lost_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            master_grant_q <= (state_d == MASTER);
            slave_grant_q  <= (state_d != MASTER);
            bus_free_q     <= (state_d == IDLE);
            arb_lost_q     <= arb_lost_d;
            timeout_q      <= stuck_done_s;
        end
    end

    assign master_grant = master_grant_q;
    assign slave_grant  = slave_grant_q;
    assign bus_free     = bus_free_q;
    assign arb_lost     = arb_lost_q;
    assign timeout      = timeout_q;

endmodule
